dmem_responder: RTL

- Responder side of the data-memory request interface driven by the memory stage.
- Accepts one load or store request at a time over a valid/ready handshake and performs it on an internal 64-bit-wide word array.
- Returns a response after a fixed, parameterised latency and holds it until the requester accepts it.
- Lets the pipeline be exercised against multi-cycle memory, with stall back-pressure through o_req_ready.

---
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, fixed-latency response
// held until accepted, back-pressure through o_req_ready.
//
// Ports:
//   i_clk, i_arst                clock, async active-low reset
//   i_req_valid / o_req_ready    request handshake
//   i_req_we, i_req_size         store flag, size (byte/half/word/double)
//   i_req_addr, i_req_wdata      byte address, right-aligned store data
//   o_rsp_valid / i_rsp_ready    response handshake
//   o_rsp_rdata, o_rsp_err       zero-extended load data, error flag
module dmem_responder #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int MEM_DEPTH  = 128,
   parameter int LATENCY    = 2
) (
   input  logic                  i_clk,
   input  logic                  i_arst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_we,
   input  logic [1:0]            i_req_size,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic                  o_rsp_err
);

   localparam int IDX_W  = $clog2(MEM_DEPTH);
   localparam int BYTE_W = IDX_W + 3;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic [IDX_W-1:0]      idx;
   logic [2:0]            off;
   logic [5:0]            sh;
   logic                  misal;
   logic                  oor;
   logic                  err;
   logic                  accept;
   logic [7:0]            lane_mask;
   logic [7:0]            lane_en;
   logic [DATA_WIDTH-1:0] size_mask;
   logic [DATA_WIDTH-1:0] wshift;
   logic [DATA_WIDTH-1:0] rword;
   logic [DATA_WIDTH-1:0] rext;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;

   // Ready is masked while reset is held so nothing is committed in reset.
   assign o_req_ready = (state_q == IDLE) && i_arst;
   assign o_rsp_valid = (state_q == RESP);
   assign o_rsp_rdata = rdata_q;
   assign o_rsp_err   = err_q;

   assign accept = i_req_valid && o_req_ready;

   assign idx = i_req_addr[BYTE_W-1:3];
   assign off = i_req_addr[2:0];
   assign sh  = {off, 3'b000};
   assign oor = |i_req_addr[ADDR_WIDTH-1:BYTE_W];
   assign err = misal || oor;

   always_comb begin
      misal     = 1'b0;
      lane_mask = 8'h00;
      size_mask = '0;
      unique case (i_req_size)
         2'b00: begin
            lane_mask = 8'h01;
            size_mask = 64'h0000_0000_0000_00FF;
         end
         2'b01: begin
            misal     = off[0];
            lane_mask = 8'h03;
            size_mask = 64'h0000_0000_0000_FFFF;
         end
         2'b10: begin
            misal     = |off[1:0];
            lane_mask = 8'h0F;
            size_mask = 64'h0000_0000_FFFF_FFFF;
         end
         2'b11: begin
            misal     = |off;
            lane_mask = 8'hFF;
            size_mask = '1;
         end
      endcase
   end

   // Aligned accesses never straddle a word, so a plain shift suffices.
   assign lane_en = lane_mask << off;
   assign wshift  = i_req_wdata << sh;
   assign rword   = mem[idx];
   assign rext    = (rword >> sh) & size_mask;

   // Array contents survive reset.
   always_ff @(posedge i_clk) begin
      if (accept && i_req_we && !err) begin
         for (int b = 0; b < 8; b++) begin
            if (lane_en[b]) begin
               mem[idx][8*b +: 8] <= wshift[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d   = CNT_INIT;
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (i_rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_arst) begin
      if (!i_arst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Response payload is captured once, at the accept edge.
   always_ff @(posedge i_clk or negedge i_arst) begin
      if (!i_arst) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         err_q   <= err;
         rdata_q <= (err || i_req_we) ? '0 : rext;
      end
   end

endmodule
